// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op encodings and FSM state type for alu_seq
package alu_seq_pkg;

    localparam int ALU_SEQ_OP_W = 4;

    typedef enum logic [ALU_SEQ_OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL1 = 4'd6,
        OP_SHR1 = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_SAR  = 4'd10,
        OP_ROL  = 4'd11,
        OP_ADC  = 4'd12,
        OP_SBB  = 4'd13,
        OP_MUL  = 4'd14,
        OP_RSVD = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_var_shift(input op_e o);
        return (o == OP_SHL) || (o == OP_SHR) || (o == OP_SAR) || (o == OP_ROL);
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - combinational single-cycle ops with carry/overflow/err generation
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  logic             carry_in,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign cin  = carry_in & ((op == OP_ADC) || (op == OP_SBB));
    assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        err   = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                y     = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL1: begin
                y     = {a[WIDTH-2:0], 1'b0};
                carry = a[WIDTH-1];
            end
            OP_SHR1: begin
                y     = {1'b0, a[WIDTH-1:1]};
                carry = a[0];
            end
            // variable shifts reach here only with a zero amount
            OP_SHL, OP_SHR, OP_SAR, OP_ROL: y = a;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: handshake, iterative shifts, optional multiply (ALU_SEQ_MUL_EN)
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic [ALU_SEQ_OP_W-1:0] op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        y,
    output logic                    carry,
    output logic                    zero,
    output logic                    neg,
    output logic                    ovf,
    output logic                    err
);

    localparam int CNT_W = SHW + 1;

    state_e           state;
    op_e              op_in;
    op_e              op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] step_work;
    logic             step_c;
    logic             shc;
    logic             res_c;
    logic             carry_q;
    logic [SHW-1:0]   amount;
    logic             accept;
    logic             iter;
    logic [WIDTH-1:0] core_y;
    logic             core_c;
    logic             core_v;
    logic             core_e;

    assign op_in    = op_e'(op);
    assign amount   = b[SHW-1:0];
    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .a        (a),
        .b        (b),
        .op       (op_in),
        .carry_in (carry_q),
        .y        (core_y),
        .carry    (core_c),
        .ovf      (core_v),
        .err      (core_e)
    );

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] opa;
    logic [WIDTH:0]   mul_sum;

    assign iter    = (is_var_shift(op_in) && (amount != '0)) || (op_in == OP_MUL);
    assign mul_sum = {1'b0, work_hi} + (work[0] ? {1'b0, opa} : '0);
    assign res_c   = (op_q == OP_MUL) ? (step_hi != '0) : step_c;
`else
    assign iter    = is_var_shift(op_in) && (amount != '0);
    assign res_c   = step_c;
`endif

    // One bit position per BUSY cycle; for MUL {work_hi, work} is the product register
    always_comb begin
        step_work = work;
        step_c    = shc;
`ifdef ALU_SEQ_MUL_EN
        step_hi   = work_hi;
`endif
        case (op_q)
            OP_SHL: begin
                step_c    = work[WIDTH-1];
                step_work = {work[WIDTH-2:0], 1'b0};
            end
            OP_SHR: begin
                step_c    = work[0];
                step_work = {1'b0, work[WIDTH-1:1]};
            end
            OP_SAR: begin
                step_c    = work[0];
                step_work = {work[WIDTH-1], work[WIDTH-1:1]};
            end
            OP_ROL: begin
                step_c    = work[WIDTH-1];
                step_work = {work[WIDTH-2:0], work[WIDTH-1]};
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                step_hi   = mul_sum[WIDTH:1];
                step_work = {mul_sum[0], work[WIDTH-1:1]};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_ADD;
            cnt       <= '0;
            work      <= '0;
            shc       <= 1'b0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            work_hi   <= '0;
            opa       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if ((state == ST_DONE) && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                    if (accept) begin
                        op_q <= op_in;
                        if (iter) begin
                            state     <= ST_BUSY;
                            out_valid <= 1'b0;
                            shc       <= 1'b0;
                            work      <= a;
                            cnt       <= {1'b0, amount};
`ifdef ALU_SEQ_MUL_EN
                            if (op_in == OP_MUL) begin
                                work    <= b;
                                work_hi <= '0;
                                opa     <= a;
                                cnt     <= CNT_W'(WIDTH);
                            end
`endif
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            y         <= core_y;
                            carry     <= core_c;
                            ovf       <= core_v;
                            err       <= core_e;
                            zero      <= (core_y == '0);
                            neg       <= core_y[WIDTH-1];
                            if (!core_e) carry_q <= core_c;
                        end
                    end
                end
                ST_BUSY: begin
                    work <= step_work;
                    shc  <= step_c;
                    cnt  <= cnt - 1'b1;
`ifdef ALU_SEQ_MUL_EN
                    work_hi <= step_hi;
`endif
                    if (cnt == CNT_W'(1)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        y         <= step_work;
                        carry     <= res_c;
                        carry_q   <= res_c;
                        ovf       <= 1'b0;
                        err       <= 1'b0;
                        zero      <= (step_work == '0);
                        neg       <= step_work[WIDTH-1];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed table-driven bench for alu_seq (WIDTH=8), MUL cases with ALU_SEQ_MUL_EN
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] y;
    logic       carry, zero, neg, ovf, err;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .carry     (carry),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic [4:0] flags;  // {carry, zero, neg, ovf, err}
        int         lat;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                                input logic [7:0] vy, input logic [4:0] f, input int l);
        vec_t v;
        v.name = n; v.op = o; v.a = va; v.b = vb; v.y = vy; v.flags = f; v.lat = l;
        return v;
    endfunction

    // Issue one op; returns at the negedge where out_valid was first seen (or budget expiry)
    task automatic run_op(input string name, input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                          output int lat);
        int w;
        @(negedge clk);
        op = o; a = va; b = vb; in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 50) chk({name, "_in_ready_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'h5A; b = 8'hC3; op = 4'd2;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;

        tv.push_back(mk("add_ff_01",  4'd0,  8'hFF, 8'h01, 8'h00, 5'b11000, 1));
        tv.push_back(mk("adc_carry",  4'd12, 8'h00, 8'h00, 8'h01, 5'b00000, 1));
        tv.push_back(mk("sub_borrow", 4'd1,  8'h10, 8'h20, 8'hF0, 5'b10100, 1));
        tv.push_back(mk("sub_ovf",    4'd1,  8'h80, 8'h01, 8'h7F, 5'b00010, 1));
        tv.push_back(mk("sbb_nocin",  4'd13, 8'h05, 8'h03, 8'h02, 5'b00000, 1));
        tv.push_back(mk("and",        4'd2,  8'hF0, 8'h3C, 8'h30, 5'b00000, 1));
        tv.push_back(mk("or",         4'd3,  8'hF0, 8'h0F, 8'hFF, 5'b00100, 1));
        tv.push_back(mk("xor_zero",   4'd4,  8'hAA, 8'hAA, 8'h00, 5'b01000, 1));
        tv.push_back(mk("not",        4'd5,  8'h55, 8'h00, 8'hAA, 5'b00100, 1));
        tv.push_back(mk("shl1",       4'd6,  8'h81, 8'h00, 8'h02, 5'b10000, 1));
        tv.push_back(mk("shr1",       4'd7,  8'h81, 8'h00, 8'h40, 5'b10000, 1));
        tv.push_back(mk("shr_by4",    4'd9,  8'h0F, 8'h04, 8'h00, 5'b11000, 5));
        tv.push_back(mk("sar_by3",    4'd10, 8'h80, 8'h03, 8'hF0, 5'b00100, 4));
        tv.push_back(mk("shl_by0",    4'd8,  8'hA5, 8'h00, 8'hA5, 5'b00100, 1));
        tv.push_back(mk("shl_by7",    4'd8,  8'h03, 8'h07, 8'h80, 5'b10100, 8));
        tv.push_back(mk("rol_by1",    4'd11, 8'h81, 8'h01, 8'h03, 5'b10000, 2));
        tv.push_back(mk("add_ovf",    4'd0,  8'h7F, 8'h01, 8'h80, 5'b00110, 1));
        tv.push_back(mk("sub_0_1",    4'd1,  8'h00, 8'h01, 8'hFF, 5'b10100, 1));
        tv.push_back(mk("op15_err",   4'd15, 8'h12, 8'h34, 8'h00, 5'b01001, 1));
        tv.push_back(mk("adc_keepcq", 4'd12, 8'h7F, 8'h00, 8'h80, 5'b00110, 1));
        tv.push_back(mk("sbb_cin0",   4'd13, 8'h00, 8'h00, 8'h00, 5'b01000, 1));
`ifdef ALU_SEQ_MUL_EN
        tv.push_back(mk("mul_0f_11",  4'd14, 8'h0F, 8'h11, 8'hFF, 5'b00100, 9));
        tv.push_back(mk("mul_10_10",  4'd14, 8'h10, 8'h10, 8'h00, 5'b11000, 9));
`else
        tv.push_back(mk("op14_err",   4'd14, 8'h0F, 8'h11, 8'h00, 5'b01001, 1));
`endif

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_y", y, 0);
        chk("rst_flags", {carry, zero, neg, ovf, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            run_op(tv[i].name, tv[i].op, tv[i].a, tv[i].b, lat);
            chk({tv[i].name, "_lat"}, lat, tv[i].lat);
            chk({tv[i].name, "_y"}, y, tv[i].y);
            chk({tv[i].name, "_flags"}, {carry, zero, neg, ovf, err}, tv[i].flags);
        end

        // back-to-back single-cycle ops, one result per cycle
        @(negedge clk);
        op = 4'd0; a = 8'h01; b = 8'h01; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b2b_valid", out_valid, 1);
            chk("b2b_y", y, 8'h01 + 8'(k) * 8'h02 + 8'h01);
            chk("b2b_in_ready", in_ready, 1);
            a = a + 8'h01; b = b + 8'h01;
        end
        in_valid = 1'b0;
        @(negedge clk);

        // backpressure: result held, then ADC accepted on the taking cycle uses its carry
        out_ready = 1'b0;
        run_op("bp_add", 4'd0, 8'hF0, 8'h20, lat);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_y", y, 8'h10);
            chk("bp_flags", {carry, zero, neg, ovf, err}, 5'b10000);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        op = 4'd12; a = 8'h00; b = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("bp_take_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_adc_valid", out_valid, 1);
        chk("bp_adc_y", y, 8'h01);

        // reset mid-BUSY: carry_q set beforehand must also be cleared
        run_op("pre_rst_sub", 4'd1, 8'h00, 8'h01, lat);
        @(negedge clk);
        op = 4'd11; a = 8'h81; b = 8'h07; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy_was_busy", out_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_valid", out_valid, 0);
        chk("rst_busy_y", y, 0);
        chk("rst_busy_flags", {carry, zero, neg, ovf, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_busy_in_ready", in_ready, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_no_stale", out_valid, 0);
        end
        run_op("post_rst_adc", 4'd12, 8'h00, 8'h00, lat);
        chk("post_rst_adc_y", y, 8'h00);
        chk("post_rst_adc_flags", {carry, zero, neg, ovf, err}, 5'b01000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
